mult_add_seq: RTL and testbench



---
 rtl/clk_arith_pkg.sv | 19 +
 rtl/mult_add_seq_if.sv | 34 +++
 rtl/mult_add_seq.sv | 87 ++++++++
 tb/tb_mult_add_seq.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/clk_arith_pkg.sv
// rtl/clk_arith_pkg.sv - shared arithmetic constants and FSM state type for the clock datapath
package clk_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_DEF = 8;

  localparam logic [7:0] TEN = 8'd10;

  // Bits needed for a counter that walks 0..w-1 (kept >= 1 so WIDTH=1 still elaborates).
  function automatic int cnt_bits(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/mult_add_seq_if.sv
// rtl/mult_add_seq_if.sv - start/done handshake and operand/result bundle for mult_add_seq
interface mult_add_seq_if #(
  parameter int WIDTH = clk_arith_pkg::WIDTH_DEF
);

  logic                   start;
  logic [WIDTH-1:0]       multiplicand;
  logic [WIDTH-1:0]       multiplier;
  logic [WIDTH-1:0]       addend;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     product;

  modport master (
    output start,
    output multiplicand,
    output multiplier,
    output addend,
    input  busy,
    input  done,
    input  product
  );

  modport slave (
    input  start,
    input  multiplicand,
    input  multiplier,
    input  addend,
    output busy,
    output done,
    output product
  );

endinterface

// File: rtl/mult_add_seq.sv
// rtl/mult_add_seq.sv - sequential shift-and-add unit: product = multiplicand * multiplier + addend
module mult_add_seq
  import clk_arith_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  mult_add_seq_if.slave bus
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = cnt_bits(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t          state;
  logic [PW-1:0]   acc;
  logic [PW-1:0]   mcand_sh;
  logic [WIDTH-1:0] mlt_sh;
  logic [CW-1:0]   cnt;
  logic            busy_q;
  logic            done_q;
  logic [PW-1:0]   product_q;
  logic [PW-1:0]   acc_next;

  // Accumulator after the current iteration's conditional add; also the final
  // product when the last iteration completes.
  always_comb begin
    acc_next = acc;
    if (mlt_sh[0]) begin
      acc_next = acc + mcand_sh;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      mcand_sh  <= '0;
      mlt_sh    <= '0;
      cnt       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            acc      <= {{WIDTH{1'b0}}, bus.addend};
            mcand_sh <= {{WIDTH{1'b0}}, bus.multiplicand};
            mlt_sh   <= bus.multiplier;
            cnt      <= '0;
            busy_q   <= 1'b1;
            state    <= CALC;
          end
        end
        CALC: begin
          acc      <= acc_next;
          mcand_sh <= mcand_sh << 1;
          mlt_sh   <= mlt_sh >> 1;
          cnt      <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            product_q <= acc_next;
            done_q    <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;

endmodule

// File: tb/tb_mult_add_seq.sv
// tb/tb_mult_add_seq.sv - self-checking bench for mult_add_seq against an arithmetic reference
module tb_mult_add_seq;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   errs = 0;
  logic [2*W-1:0] last_product = '0;

  mult_add_seq_if #(.WIDTH(W)) bus ();

  mult_add_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] ref_model(input int unsigned a, input int unsigned b,
                                               input int unsigned c);
    return (2*W)'(a * b + c);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic scramble_inputs();
    bus.multiplicand = 8'($urandom);
    bus.multiplier   = 8'($urandom);
    bus.addend       = 8'($urandom);
  endtask

  // One operation from IDLE; optionally pokes start again 3 cycles after acceptance.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                        input string tag, input bit interfere);
    int done_at;
    int pulses;
    logic [2*W-1:0] exp;
    done_at = -1;
    pulses  = 0;
    exp     = ref_model(a, b, c);
    @(negedge clk);
    bus.start = 1'b1;
    bus.multiplicand = a;
    bus.multiplier   = b;
    bus.addend       = c;
    @(negedge clk);
    bus.start = 1'b0;
    scramble_inputs();
    check({tag, "_busy_rise"}, 32'(bus.busy), 32'd1);
    for (int k = 0; k <= W + 2; k++) begin
      if (k > 0) @(negedge clk);
      if (interfere && k == 2) begin
        bus.start = 1'b1;
        scramble_inputs();
      end
      if (interfere && k == 3) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        pulses++;
        if (done_at < 0) done_at = k;
      end
      if (k == W - 1) check({tag, "_product_held"}, 32'(bus.product), 32'(last_product));
      if (k == W)     check({tag, "_product"}, 32'(bus.product), 32'(exp));
      if (k == W + 1) check({tag, "_busy_fall"}, 32'(bus.busy), 32'd0);
    end
    check({tag, "_done_latency"}, 32'(done_at), 32'(W));
    check({tag, "_done_pulses"}, 32'(pulses), 32'd1);
    check({tag, "_product_after"}, 32'(bus.product), 32'(exp));
    last_product = exp;
  endtask

  initial begin
    logic [7:0] oa [40];
    logic [7:0] ob [40];
    logic [7:0] oc [40];
    logic [2*W-1:0] held;
    int pulses;

    bus.start = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    bus.addend       = '0;

    #12;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_product", 32'(bus.product), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_no_start_busy", 32'(bus.busy), 32'd0);

    run_op(8'd7,   8'd12,  8'd5,   "basic",   1'b0);
    check("basic_value", 32'(last_product), 32'd89);
    run_op(8'd7,   8'd28,  8'd4,   "divider", 1'b0);
    check("divider_value", 32'(last_product), 32'd200);
    run_op(8'd255, 8'd255, 8'd255, "max",     1'b0);
    check("max_value", 32'(last_product), 32'd65280);
    run_op(8'd0,   8'd200, 8'd9,   "zero_a",  1'b0);
    run_op(8'd10,  8'd0,   8'd0,   "zero_b",  1'b0);
    run_op(8'd13,  8'd9,   8'd2,   "ignore_start", 1'b1);

    // Reset in the middle of an operation.
    @(negedge clk);
    bus.start = 1'b1;
    bus.multiplicand = 8'd100;
    bus.multiplier   = 8'd3;
    bus.addend       = 8'd1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_product", 32'(bus.product), 32'd0);
    pulses = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.done === 1'b1) pulses++;
    end
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (bus.done === 1'b1) pulses++;
    end
    check("abort_no_done", 32'(pulses), 32'd0);
    check("abort_idle", 32'(bus.busy), 32'd0);
    last_product = '0;
    run_op(8'd10, 8'd5, 8'd9, "after_reset", 1'b0);
    check("after_reset_value", 32'(last_product), 32'd59);

    for (int i = 0; i < 16; i++) begin
      run_op(8'($urandom), 8'($urandom), 8'($urandom), $sformatf("rand%0d", i), 1'b0);
    end

    // start held high: acceptances every W+2 edges, fresh random operands every cycle.
    held = last_product;
    @(negedge clk);
    for (int j = 0; j < 32; j++) begin
      bus.start = 1'b1;
      oa[j] = 8'($urandom);
      ob[j] = 8'($urandom);
      oc[j] = 8'($urandom);
      bus.multiplicand = oa[j];
      bus.multiplier   = ob[j];
      bus.addend       = oc[j];
      @(negedge clk);
      check($sformatf("cont_done_%0d", j), 32'(bus.done), 32'((j % (W + 2)) == W));
      if ((j % (W + 2)) == W) held = ref_model(oa[j-W], ob[j-W], oc[j-W]);
      check($sformatf("cont_product_%0d", j), 32'(bus.product), 32'(held));
    end
    bus.start = 1'b0;
    repeat (W + 2) @(negedge clk);
    check("cont_last_product", 32'(bus.product), 32'(ref_model(oa[30], ob[30], oc[30])));
    check("cont_drained", 32'(bus.busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
